// File: rtl/i2s_pkg.sv
// ============================================================================
// Module  : i2s_pkg
// Purpose : Shared types and constants for the I2S SCK/WS timing generator.
//           Macro I2S_LEFT_JUSTIFIED_EN selects the zero-delay data format.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

  // Generator run state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  // Word-select polarity
  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  // Data delay in SCK periods between the ws edge and the slot MSB
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int DATA_DELAY = 0;
`else
  localparam int DATA_DELAY = 1;
`endif

  // Width of a counter spanning both channel slots of one frame
  function automatic int slot_width(input int word_bits);
    return $clog2(2 * word_bits);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_clk_div.sv
// ============================================================================
// Module  : i2s_clk_div
// Purpose : SCK half-period divider. Counts 0..div_q while running and emits
//           a toggle strobe on the terminal count. div_q is only reloaded on
//           request so a frame always runs at one rate.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             reload,
  input  logic [DIV_W-1:0] div_cfg,
  output logic             toggle
);

  logic [DIV_W-1:0] r_div_q;
  logic [DIV_W-1:0] r_div_cnt;

  // Terminal count of the half period; suppressed while stopped
  assign toggle = run && (r_div_cnt == r_div_q);

  // Divider reload register: frame-rate configuration snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_q <= '0;
    end else if (reload) begin
      r_div_q <= div_cfg;
    end
  end

  // Half-period counter; clears on terminal count so all-ones cannot wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (!run || toggle) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2s_sck_ws_gen.sv
// ============================================================================
// Module  : i2s_sck_ws_gen
// Purpose : Master-mode I2S timing generator. Produces sck, ws, edge strobes,
//           the serialiser bit index and a per-frame pulse.
//           Macro I2S_LEFT_JUSTIFIED_EN selects left-justified bit indexing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_sck_ws_gen
  import i2s_pkg::*;
#(
  parameter int WORD_BITS = 16,
  parameter int DIV_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [DIV_W-1:0]             div_cfg,
  output logic                         sck,
  output logic                         ws,
  output logic                         sck_rise,
  output logic                         sck_fall,
  output logic [$clog2(WORD_BITS)-1:0] bit_idx,
  output logic                         frame_pulse,
  output logic                         busy
);

  localparam int SLOT_W = slot_width(WORD_BITS);
  localparam int BIT_W  = $clog2(WORD_BITS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * WORD_BITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(WORD_BITS);

  state_e            r_state;
  state_e            w_next_state;
  logic [SLOT_W-1:0] r_slot_cnt;
  logic [SLOT_W-1:0] w_slot_next;
  logic              w_run;
  logic              w_reload;
  logic              w_toggle;
  logic              w_wrap;
  int                w_bit_pos;

  // Divider runs in RUN and STOP; reloads on start and at each frame wrap
  assign w_run       = (r_state != IDLE);
  assign w_wrap      = w_toggle && sck && (r_slot_cnt == SLOT_LAST);
  assign w_reload    = ((r_state == IDLE) && enable) || w_wrap;
  assign w_slot_next = (r_slot_cnt == SLOT_LAST) ? '0 : r_slot_cnt + 1'b1;

  i2s_clk_div #(
    .DIV_W (DIV_W)
  ) u_clk_div (
    .clk     (clk),
    .rst     (rst),
    .run     (w_run),
    .reload  (w_reload),
    .div_cfg (div_cfg),
    .toggle  (w_toggle)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; STOP only drops to IDLE in the frame-pulse cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = enable ? RUN : IDLE;
      RUN:     w_next_state = enable ? RUN : STOP;
      STOP: begin
        if (enable) begin
          w_next_state = RUN;
        end else if (frame_pulse) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = STOP;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs derived from state: busy flag and bit index of the current slot
  always_comb begin
    busy      = (r_state != IDLE);
    bit_idx   = '0;
    w_bit_pos = 0;
    if (r_state != IDLE) begin
      w_bit_pos = ((int'(r_slot_cnt) + 2 * WORD_BITS - DATA_DELAY) % (2 * WORD_BITS)) % WORD_BITS;
      bit_idx   = BIT_W'(WORD_BITS - 1 - w_bit_pos);
    end
  end

  // sck/ws/slot registers and strobes, all updated on divider toggles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck         <= 1'b0;
      ws          <= WS_LEFT;
      sck_rise    <= 1'b0;
      sck_fall    <= 1'b0;
      frame_pulse <= 1'b0;
      r_slot_cnt  <= '0;
    end else if (w_next_state == IDLE) begin
      sck         <= 1'b0;
      ws          <= WS_LEFT;
      sck_rise    <= 1'b0;
      sck_fall    <= 1'b0;
      frame_pulse <= 1'b0;
      r_slot_cnt  <= '0;
    end else begin
      sck_rise    <= w_toggle && !sck;
      sck_fall    <= w_toggle && sck;
      frame_pulse <= w_wrap;
      if (w_toggle) begin
        sck <= ~sck;
        if (sck) begin
          r_slot_cnt <= w_slot_next;
          ws         <= (w_slot_next >= SLOT_HALF) ? WS_RIGHT : WS_LEFT;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2s_sck_ws_gen.sv
// ============================================================================
// Module  : tb_i2s_sck_ws_gen
// Purpose : Self-checking bench for i2s_sck_ws_gen. A frame-position model
//           predicts every output each cycle; directed phases pin timing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_sck_ws_gen;

  localparam int W     = 16;
  localparam int DIV_W = 8;
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int TB_DELAY  = 0;
  localparam int LIT_BIT_0 = 15;
  localparam int LIT_BIT_1 = 14;
`else
  localparam int TB_DELAY  = 1;
  localparam int LIT_BIT_0 = 0;
  localparam int LIT_BIT_1 = 15;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] div_cfg = 8'd1;
  logic             sck, ws, sck_rise, sck_fall, frame_pulse, busy;
  logic [3:0]       bit_idx;

  int n_tests = 0;
  int n_fail  = 0;

  i2s_sck_ws_gen #(.WORD_BITS(W), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .div_cfg     (div_cfg),
    .sck         (sck),
    .ws          (ws),
    .sck_rise    (sck_rise),
    .sck_fall    (sck_fall),
    .bit_idx     (bit_idx),
    .frame_pulse (frame_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model: position within the frame ----------
  // m_k counts clk cycles since the frame (or run) started; m_d is the
  // half-period-minus-1 in force for that frame.
  int m_busy = 0, m_stop = 0, m_first = 0, m_k = 0, m_d = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_stop = 0; m_first = 0; m_k = 0; m_d = 0;
    end else if (m_busy == 0) begin
      if (enable) begin
        m_busy = 1; m_stop = 0; m_k = 0; m_d = int'(div_cfg); m_first = 1;
      end
    end else begin
      if (m_stop != 0 && m_k == 0 && m_first == 0 && !enable) begin
        m_busy = 0;
      end else begin
        m_stop = enable ? 0 : 1;
        if (m_k == 4 * W * (m_d + 1) - 1) begin
          m_k = 0; m_d = int'(div_cfg); m_first = 0;
        end else begin
          m_k++;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (!rst) begin
      int h, ph, slot, e_sck, e_ws, e_rise, e_fall, e_fp, e_bit, s;
      logic [9:0] e_vec;
      e_sck = 0; e_ws = 0; e_rise = 0; e_fall = 0; e_fp = 0; e_bit = 0;
      if (m_busy != 0) begin
        h      = m_k / (m_d + 1);
        ph     = m_k % (m_d + 1);
        e_sck  = h % 2;
        slot   = h / 2;
        e_ws   = (slot >= W) ? 1 : 0;
        e_rise = (ph == 0 && e_sck == 1) ? 1 : 0;
        e_fall = (ph == 0 && e_sck == 0 && (h > 0 || m_first == 0)) ? 1 : 0;
        e_fp   = (m_k == 0 && m_first == 0) ? 1 : 0;
        s      = ((slot + 2 * W - TB_DELAY) % (2 * W)) % W;
        e_bit  = W - 1 - s;
      end
      e_vec = {e_sck[0], e_ws[0], e_rise[0], e_fall[0], e_fp[0], m_busy[0], e_bit[3:0]};
      chk("cycle_outputs{sck,ws,rise,fall,fp,busy,bit}",
          {sck, ws, sck_rise, sck_fall, frame_pulse, busy, bit_idx}, e_vec);
    end
  end

  // ---------------- helpers ----------------
  function automatic logic sel(input int which);
    case (which)
      0:       return frame_pulse;
      1:       return sck_rise;
      2:       return sck_fall;
      3:       return busy;
      4:       return ws;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel(which) && n < bound);
    if (!sel(which)) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_timeout sig=%0d waited=%0d", which, n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, tot, cnt;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sck, ws, sck_rise, sck_fall, frame_pulse, busy, bit_idx}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {sck, ws, sck_rise, sck_fall, frame_pulse, busy, bit_idx}, 0);

    // div_cfg=1, enable held: frame 128, ws half 64, sck period 4
    enable = 1'b1;
    wait_sig(0, 400, n);  chk("first_fp_latency", n, 129);
    chk("fp_with_fall", sck_fall, 1);
    chk("fp_ws_left", ws, 0);
    wait_sig(4, 200, n);  chk("ws_left_len", n, 64);
    wait_sig(0, 200, n);  chk("ws_right_len", n, 64);
    wait_sig(1, 20, n);
    wait_sig(1, 20, n);   chk("sck_period_div1", n, 4);

    // div_cfg 1->3 at clk 50 of a frame
    wait_sig(0, 200, n);
    repeat (50) @(negedge clk);
    div_cfg = 8'd3;
    wait_sig(0, 200, n);  chk("frame_keeps_old_div", n, 78);
    wait_sig(0, 400, n);  chk("frame_uses_new_div", n, 256);

    // Deassert enable at slot 5: one final pulse, then IDLE
    for (int i = 0; i < 5; i++) wait_sig(2, 20, n);
    enable = 1'b0;
    wait_sig(0, 400, n);  chk("final_fp_delay", n, 216);
    chk("busy_at_final_fp", busy, 1);
    @(negedge clk);
    chk("idle_after_stop", {busy, sck, ws}, 0);
    cnt = 0;
    repeat (600) begin
      @(negedge clk);
      if (frame_pulse) cnt++;
    end
    chk("no_fp_after_stop", cnt, 0);

    // Reassert enable during STOP: frame length unchanged
    enable = 1'b1;
    wait_sig(0, 400, n);  chk("restart_fp_latency", n, 257);
    tot = 0;
    for (int i = 0; i < 3; i++) begin wait_sig(2, 20, n); tot += n; end
    enable = 1'b0;
    repeat (10) @(negedge clk);
    tot += 10;
    enable = 1'b1;
    wait_sig(0, 400, n);  tot += n;
    chk("stop_resume_frame_len", tot, 256);

    // div_cfg=0: bit index sequence at the start of the left slot
    div_cfg = 8'd0;
    wait_sig(0, 400, n);
    chk("div0_k0_sck", sck, 0);
    chk("div0_k0_bit", bit_idx, LIT_BIT_0);
    @(negedge clk);
    chk("div0_k1_sck", sck, 1);
    chk("div0_k1_bit", bit_idx, LIT_BIT_0);
    @(negedge clk);
    chk("div0_k2_sck", sck, 0);
    chk("div0_k2_bit", bit_idx, LIT_BIT_1);
    wait_sig(0, 100, n);  chk("div0_frame_len", n, 62);

    // Async reset at slot 20, then restart
    div_cfg = 8'd1;
    wait_sig(0, 200, n);
    for (int i = 0; i < 20; i++) wait_sig(2, 20, n);
    chk("pre_reset_busy_ws", {busy, ws}, 2'b11);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {sck, ws, sck_rise, sck_fall, frame_pulse, busy, bit_idx}, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_sig(3, 10, n);   chk("restart_busy", n, 1);
    wait_sig(0, 200, n);  chk("restart_first_fp", n, 128);

    // div_cfg all-ones: sck period 512
    div_cfg = 8'hFF;
    wait_sig(0, 200, n);
    wait_sig(1, 600, n);  chk("div255_first_rise", n, 256);
    wait_sig(1, 600, n);  chk("div255_period", n, 512);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; enable = 1'b0;

    // Randomised enable / div_cfg / reset traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) div_cfg = DIV_W'($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
